conv_job_sched: RTL
===================

CONV_JOB_SCHED -- requirements
Module: conv_job_sched

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued job descriptors (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port job_valid, input, 1 bit: the host offers a descriptor.
REQ-005 The block SHALL have port job_ready, output, 1 bit: the descriptor FIFO is not full.
REQ-006 The block SHALL have port job_desc, input, 42 bits: {wr 1, startAddr 5, stride 4, startLat 16, endLat 16}, with endLat in the LSBs.
REQ-007 The block SHALL have port abort, input, 1 bit: a synchronous flush request.
REQ-008 The block SHALL have outputs startAddr (5), strideInterval (4), startLatency (16), endLatency (16) and writeEn (1), which drive the memory/compute datapath.
REQ-009 The block SHALL have port valid, output, 1 bit: a one-cycle launch strobe to the datapath.
REQ-010 The block SHALL have outputs busy (1), done (1, pulse) and err (1, sticky).

Function
REQ-011 A descriptor SHALL be accepted on any edge where job_valid and job_ready are both high; it is written to the FIFO tail.
REQ-012 job_ready SHALL be low whenever the FIFO holds FIFO_DEPTH entries; there is no bypass path.
REQ-013 The FSM SHALL have states IDLE, LAUNCH, RUN and FIN.
REQ-014 IDLE: if the FIFO is non-empty, the block SHALL pop the head into the output registers and go to LAUNCH; otherwise it stays in IDLE.
REQ-015 Pop check: a popped descriptor with endLat < startLat SHALL be dropped, SHALL set err, and the FSM SHALL stay in IDLE.
REQ-016 LAUNCH: valid SHALL be high for exactly this one cycle; the run counter loads 1; next state is RUN.
REQ-017 RUN: the counter SHALL increment each cycle; when counter >= max(endLat,1) the next state is FIN.
REQ-018 FIN: done SHALL be high for one cycle, then the FSM returns to IDLE.
REQ-019 Timing: with an empty FIFO and the FSM in IDLE, a descriptor accepted at edge N SHALL produce valid high in the cycle following edge N+2.
REQ-020 Duration: from valid to done SHALL be max(endLat,1)+1 cycles.
REQ-021 The output fields SHALL hold the values of the last launched job until the next pop.
REQ-022 busy SHALL be high when the state is not IDLE or the FIFO is non-empty.
REQ-023 Push and pop SHALL be allowed on the same edge; FIFO occupancy is then unchanged.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 When abort is high at an edge, the block SHALL empty the FIFO, return the FSM to IDLE and suppress done; any push on that same edge is discarded.
REQ-026 abort SHALL clear err.

Reset
REQ-027 While rst is low, the block SHALL hold: state IDLE, FIFO empty, valid 0, done 0, err 0, busy 0, and all field outputs 0.
REQ-028 A reset asserted mid-RUN SHALL abandon the job immediately, with no done pulse.
REQ-029 job_ready SHALL be 1 after reset.

Configuration
REQ-030 When macro CONV_JOB_SCHED_PERF_EN is defined, the block SHALL add output job_count (16 bits), which increments on each done and saturates at 16'hFFFF; it is cleared by reset only.
REQ-031 When CONV_JOB_SCHED_PERF_EN is undefined, job_count SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Single job: push {wr=1, addr 0, stride 1, startLat 0, endLat 9} at edge N -> valid high after edge N+2 with writeEn=1 and endLatency=9; done follows 10 cycles after valid.
REQ-033 Back-to-back jobs: push {0,0,1,9,12} then {0,5,1,15,20} -> second valid 2 cycles after first done; startAddr=5 and startLatency=15 on the second launch.
REQ-034 Full FIFO: with FIFO_DEPTH=4, push 5 jobs while the first is in RUN -> job_ready low after the 4th accept; the 5th is accepted one cycle after the next pop.
REQ-035 Error path: push {startLat 20, endLat 12} -> no valid, err=1 and stays 1; a following good job still launches; abort then clears err.
REQ-036 Abort and reset: abort mid-RUN with 2 jobs queued -> IDLE next cycle, busy=0, no done, no further valid; rst low mid-RUN -> all outputs 0 asynchronously.
REQ-037 With CONV_JOB_SCHED_PERF_EN defined: 3 completed jobs -> job_count=3; an aborted job does not count.

Source files
------------

// File: rtl/conv_job_sched.sv
// Convolution job scheduler: queues 42-bit job descriptors in a FIFO and sequences them onto the datapath.
// Optional feature: define CONV_JOB_SCHED_PERF_EN to add the saturating job_count output.
module conv_job_sched #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [41:0] job_desc,
   input  logic        abort,
   output logic [4:0]  startAddr,
   output logic [3:0]  strideInterval,
   output logic [15:0] startLatency,
   output logic [15:0] endLatency,
   output logic        writeEn,
   output logic        valid,
   output logic        busy,
   output logic        done,
   output logic        err
`ifdef CONV_JOB_SCHED_PERF_EN
   ,output logic [15:0] job_count
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FIN} state_e;

   typedef struct packed {
      logic        wr;
      logic [4:0]  start_addr;
      logic [3:0]  stride;
      logic [15:0] start_lat;
      logic [15:0] end_lat;
   } desc_t;

   state_e        state_q, state_d;
   desc_t         mem_q [FIFO_DEPTH];
   desc_t         desc_q, desc_d, head;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   cnt_q, cnt_d, end_max;
   logic          valid_q, valid_d, done_q, done_d, err_q, err_d;
   logic          push, pop, head_bad, launch_load;

   // No bypass: a full FIFO refuses a push even when a pop happens on the same edge.
   assign job_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
   assign push        = job_valid & job_ready & ~abort;
   assign head        = mem_q[rd_ptr_q];
   assign head_bad    = (head.end_lat < head.start_lat);
   assign pop         = (state_q == IDLE) & (count_q != '0) & ~abort;
   assign launch_load = pop & ~head_bad;
   assign end_max     = (desc_q.end_lat == '0) ? 16'd1 : desc_q.end_lat;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (launch_load) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (cnt_q >= end_max) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Launch and done strobes are registered, so each appears one cycle after its state.
   always_comb begin
      valid_d = (state_q == LAUNCH) & ~abort;
      done_d  = (state_q == FIN) & ~abort;
      cnt_d   = cnt_q;
      if (state_q == LAUNCH)   cnt_d = 16'd1;
      else if (state_q == RUN) cnt_d = cnt_q + 16'd1;
      err_d   = abort ? 1'b0 : (err_q | (pop & head_bad));
      desc_d  = launch_load ? head : desc_q;
   end

   always_comb begin
      wr_ptr_d = abort ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d = abort ? '0 : rd_ptr_q + AW'(pop);
      count_d  = abort ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         desc_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         desc_q   <= desc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // NOTE: FIFO storage is not reset; entries are only read while count_q says they are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= job_desc;
   end

   assign startAddr      = desc_q.start_addr;
   assign strideInterval = desc_q.stride;
   assign startLatency   = desc_q.start_lat;
   assign endLatency     = desc_q.end_lat;
   assign writeEn        = desc_q.wr;
   assign valid          = valid_q;
   assign done           = done_q;
   assign err            = err_q;
   assign busy           = (state_q != IDLE) | (count_q != '0);

`ifdef CONV_JOB_SCHED_PERF_EN
   logic [15:0] job_count_q, job_count_d;

   assign job_count_d = (done_d && job_count_q != 16'hFFFF) ? job_count_q + 16'd1 : job_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) job_count_q <= '0;
      else      job_count_q <= job_count_d;
   end

   assign job_count = job_count_q;
`endif

endmodule
